// File: rtl/exc_pkg.sv
// Shared types and PC-select encodings for the exception redirect controller.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } exc_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OPC  = 2'b01,
    CAUSE_OVF  = 2'b10
  } exc_cause_t;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_EXC = 2'd2;

endpackage

// File: rtl/exc_redirect_ctrl.sv
// Trap/return redirect controller: records EPC and cause, fetches the handler
// vector from memory (with timeout fallback) and steers the PC mux.
module exc_redirect_ctrl
  import exc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] VEC_ADDR_OPC = 64'd254,
  parameter logic [XLEN-1:0] VEC_ADDR_OVF = 64'd255,
  parameter int              MEM_TIMEOUT  = 8,
  parameter logic [XLEN-1:0] DEFAULT_VEC  = 64'd0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] cur_pc,
  input  logic            branch_taken,
  input  logic            exc_opcode,
  input  logic            exc_overflow,
  input  logic            exc_return,
  output logic            mem_rd_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic [1:0]      mux_pc_signal,
  output logic [XLEN-1:0] pc_exception,
  output logic            pc_write,
  output logic            stall,
  output logic [XLEN-1:0] epc,
  output logic [1:0]      cause
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  exc_state_t      r_state;
  exc_cause_t      r_cause;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_pc_exception;
  logic [XLEN-1:0] r_mem_addr;
  logic            r_mem_rd_req;
  logic [TW-1:0]   r_timer;
  logic            w_trap;

  assign w_trap = exc_opcode | exc_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cause        <= CAUSE_NONE;
      r_epc          <= '0;
      r_pc_exception <= '0;
      r_mem_addr     <= '0;
      r_mem_rd_req   <= 1'b0;
      r_timer        <= '0;
    end else begin
      r_mem_rd_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trap) begin
            r_epc        <= cur_pc;
            r_cause      <= exc_opcode ? CAUSE_OPC : CAUSE_OVF;
            r_mem_addr   <= exc_opcode ? VEC_ADDR_OPC : VEC_ADDR_OVF;
            r_mem_rd_req <= 1'b1;
            r_timer      <= '0;
            r_state      <= FETCH;
          end else if (exc_return) begin
            r_pc_exception <= r_epc;
            r_cause        <= CAUSE_NONE;
            r_state        <= REDIRECT;
          end
        end
        FETCH: begin
          if (mem_rvalid) begin
            r_pc_exception <= mem_rdata;
            r_state        <= REDIRECT;
          end else if (r_timer == TIMER_LAST) begin
            // Memory never answered: fall back so the core cannot hang.
            r_pc_exception <= DEFAULT_VEC;
            r_state        <= REDIRECT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        REDIRECT: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  // In IDLE a trap holds the PC so the faulting instruction is not skipped.
  always_comb begin
    mux_pc_signal = PCSEL_SEQ;
    pc_write      = 1'b1;
    stall         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trap) begin
          pc_write = 1'b0;
        end else if (!exc_return && branch_taken) begin
          mux_pc_signal = PCSEL_BR;
        end
      end
      FETCH: begin
        pc_write = 1'b0;
        stall    = 1'b1;
      end
      REDIRECT: begin
        mux_pc_signal = PCSEL_EXC;
        stall         = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_rd_req   = r_mem_rd_req;
  assign mem_addr     = r_mem_addr;
  assign pc_exception = r_pc_exception;
  assign epc          = r_epc;
  assign cause        = r_cause;

endmodule
